// File: rtl/pipelined_adder_if.sv
// Operand/result bus of the pipelined adder.
// Handshake: a transfer happens on a rising edge where valid && ready; the source holds its payload until then.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             io_enq_valid;
  logic             io_enq_ready;
  logic             io_enq_sub;
  logic             io_enq_cin;
  logic [WIDTH-1:0] io_enq_lhs;
  logic [WIDTH-1:0] io_enq_rhs;
  logic             io_deq_valid;
  logic             io_deq_ready;
  logic [WIDTH-1:0] io_deq_out;
  logic             io_deq_cout;
  logic             io_deq_ovf;

  modport master (
    output io_enq_valid, io_enq_sub, io_enq_cin, io_enq_lhs, io_enq_rhs, io_deq_ready,
    input  io_enq_ready, io_deq_valid, io_deq_out, io_deq_cout, io_deq_ovf
  );

  modport slave (
    input  io_enq_valid, io_enq_sub, io_enq_cin, io_enq_lhs, io_enq_rhs, io_deq_ready,
    output io_enq_ready, io_deq_valid, io_deq_out, io_deq_cout, io_deq_ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Add/subtract unit whose carry chain is cut into STAGES registered chunks.
// Every stage is an elastic slot: it loads whenever it is empty or its downstream moves.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  pipelined_adder_if.slave io
);
  localparam int C  = WIDTH / STAGES;
  localparam int CW = C + 1;

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_sub;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_res [STAGES];

  logic [STAGES-1:0] w_rdy;
  logic [STAGES-1:0] w_in_v;
  logic [STAGES-1:0] w_in_c;
  logic [STAGES-1:0] w_in_sub;
  logic [WIDTH-1:0]  w_in_a    [STAGES];
  logic [WIDTH-1:0]  w_in_b    [STAGES];
  logic [WIDTH-1:0]  w_in_res  [STAGES];
  logic [WIDTH-1:0]  w_res_nxt [STAGES];
  logic [C:0]        w_sum     [STAGES];

  always_comb begin
    w_in_v    = '0;
    w_in_c    = '0;
    w_in_sub  = '0;
    w_rdy     = '0;
    w_in_a    = '{default: '0};
    w_in_b    = '{default: '0};
    w_in_res  = '{default: '0};
    w_res_nxt = '{default: '0};
    w_sum     = '{default: '0};

    // Subtraction is lhs + ~rhs + ~cin; the operand is inverted once on entry.
    w_in_v[0]   = io.io_enq_valid;
    w_in_sub[0] = io.io_enq_sub;
    w_in_c[0]   = io.io_enq_cin ^ io.io_enq_sub;
    w_in_a[0]   = io.io_enq_lhs;
    w_in_b[0]   = io.io_enq_sub ? ~io.io_enq_rhs : io.io_enq_rhs;

    for (int k = 1; k < STAGES; k++) begin
      w_in_v[k]   = r_v[k-1];
      w_in_sub[k] = r_sub[k-1];
      w_in_c[k]   = r_c[k-1];
      w_in_a[k]   = r_a[k-1];
      w_in_b[k]   = r_b[k-1];
      w_in_res[k] = r_res[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      w_sum[k] = {1'b0, w_in_a[k][k*C +: C]} + {1'b0, w_in_b[k][k*C +: C]} + CW'(w_in_c[k]);
      w_res_nxt[k] = w_in_res[k];
      w_res_nxt[k][k*C +: C] = w_sum[k][C-1:0];
      // Stage k can move iff deq is ready or some stage from k downward is empty.
      w_rdy[k] = io.io_deq_ready || !(&(r_v | ((STAGES'(1) << k) - STAGES'(1))));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v   <= '0;
      r_c   <= '0;
      r_sub <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_res[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_v[k]   <= w_in_v[k];
          r_c[k]   <= w_sum[k][C];
          r_sub[k] <= w_in_sub[k];
          r_a[k]   <= w_in_a[k];
          r_b[k]   <= w_in_b[k];
          r_res[k] <= w_res_nxt[k];
        end
      end
    end
  end

  assign io.io_enq_ready = w_rdy[0];
  assign io.io_deq_valid = r_v[STAGES-1];
  assign io.io_deq_out   = r_res[STAGES-1];
  assign io.io_deq_cout  = r_c[STAGES-1] ^ r_sub[STAGES-1];
  assign io.io_deq_ovf   = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1]) &&
                           (r_res[STAGES-1][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder at WIDTH=8, STAGES=2: directed vector table, stall,
// random-bubble stream and mid-stream reset, all scored against an arithmetic model.
module tb_pipelined_adder;
  localparam int W  = 8;
  localparam int RW = W + 2;

  typedef struct {
    logic         sub;
    logic         cin;
    logic [W-1:0] lhs;
    logic [W-1:0] rhs;
    logic [W-1:0] out;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic clk;
  logic reset;

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(.WIDTH(W), .STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_pop    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] model(input logic sub, input logic cin,
                                          input logic [W-1:0] l, input logic [W-1:0] r);
    logic [W:0] t;
    logic       ovf;
    if (!sub) begin
      t   = {1'b0, l} + {1'b0, r} + (W+1)'(cin);
      ovf = (l[W-1] == r[W-1]) && (t[W-1] != l[W-1]);
    end else begin
      t   = {1'b0, l} - {1'b0, r} - (W+1)'(cin);
      ovf = (l[W-1] != r[W-1]) && (t[W-1] != l[W-1]);
    end
    return {t[W-1:0], t[W], ovf};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (bus.io_enq_valid && bus.io_enq_ready)
        exp_q.push_back(model(bus.io_enq_sub, bus.io_enq_cin, bus.io_enq_lhs, bus.io_enq_rhs));
      if (bus.io_deq_valid && bus.io_deq_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          chk("deq_unexpected", 32'd1, 32'd0);
        end else begin
          chk("deq_result", {22'd0, bus.io_deq_out, bus.io_deq_cout, bus.io_deq_ovf},
              {22'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic valid);
    bus.io_enq_valid = valid;
    bus.io_enq_sub   = v.sub;
    bus.io_enq_cin   = v.cin;
    bus.io_enq_lhs   = v.lhs;
    bus.io_enq_rhs   = v.rhs;
  endtask

  // One op into an empty pipe: checks acceptance, 2-edge latency and hand-computed result.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v, 1'b1);
    bus.io_deq_ready = 1'b1;
    #1;
    chk({tag, "_enq_ready"}, 32'(bus.io_enq_ready), 32'd1);
    tick();
    bus.io_enq_valid = 1'b0;
    chk({tag, "_lat_edge1"}, 32'(bus.io_deq_valid), 32'd0);
    tick();
    chk({tag, "_lat_edge2"}, 32'(bus.io_deq_valid), 32'd1);
    chk({tag, "_out"},  32'(bus.io_deq_out),  32'(v.out));
    chk({tag, "_cout"}, 32'(bus.io_deq_cout), 32'(v.cout));
    chk({tag, "_ovf"},  32'(bus.io_deq_ovf),  32'(v.ovf));
  endtask

  // ---------------- test ----------------
  vec_t          vecs [12];
  vec_t          bp   [5];
  vec_t          rv;
  vec_t          mr;
  logic [RW-1:0] m;
  logic [W-1:0]  hold_out;
  int            idx;
  int            pop0;
  int            issued;
  logic          acc;
  logic          pending;

  initial begin
    //           sub   cin   lhs    rhs    out    cout  ovf
    vecs[0]  = '{1'b0, 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 8'h10, 8'h0F, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h08, 8'h08, 8'h10, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};

    bp[0] = '{1'b0, 1'b0, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0};
    bp[1] = '{1'b1, 1'b0, 8'h50, 8'h20, 8'h00, 1'b0, 1'b0};
    bp[2] = '{1'b0, 1'b1, 8'h0F, 8'h0F, 8'h00, 1'b0, 1'b0};
    bp[3] = '{1'b1, 1'b1, 8'h03, 8'h09, 8'h00, 1'b0, 1'b0};
    bp[4] = '{1'b0, 1'b0, 8'h7F, 8'h7F, 8'h00, 1'b0, 1'b0};

    reset = 1'b0;
    drive(vecs[0], 1'b0);
    bus.io_deq_ready = 1'b1;
    #12;
    chk("rst_deq_valid", 32'(bus.io_deq_valid), 32'd0);
    chk("rst_deq_out",   32'(bus.io_deq_out),   32'd0);
    chk("rst_deq_cout",  32'(bus.io_deq_cout),  32'd0);
    chk("rst_deq_ovf",   32'(bus.io_deq_ovf),   32'd0);
    chk("rst_enq_ready", 32'(bus.io_enq_ready), 32'd1);
    tick();
    #1 reset = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    tick();
    chk("vec_queue_empty", 32'(exp_q.size()), 32'd0);

    // Back-pressure: consumer stalled, producer streams.
    bus.io_deq_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(bp[idx < 5 ? idx : 4], idx < 5);
      #1;
      acc = bus.io_enq_valid && bus.io_enq_ready;
      tick();
      if (acc) idx++;
    end
    m = model(bp[0].sub, bp[0].cin, bp[0].lhs, bp[0].rhs);
    chk("bp_accepts",   32'(idx), 32'd2);
    chk("bp_enq_ready", 32'(bus.io_enq_ready), 32'd0);
    chk("bp_deq_valid", 32'(bus.io_deq_valid), 32'd1);
    chk("bp_hold_first", 32'(bus.io_deq_out), 32'(m[RW-1:2]));
    hold_out = bus.io_deq_out;
    tick();
    tick();
    chk("bp_stable", 32'(bus.io_deq_out), 32'(hold_out));

    pop0 = n_pop;
    bus.io_deq_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(bp[idx < 5 ? idx : 4], idx < 5);
      #1;
      acc = bus.io_enq_valid && bus.io_enq_ready;
      tick();
      if (acc) idx++;
    end
    bus.io_enq_valid = 1'b0;
    chk("bp_all_accepted", 32'(idx), 32'd5);
    chk("bp_no_gaps", 32'(n_pop - pop0), 32'd5);
    tick();
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random bubbles on both sides; the payload holds until accepted.
    issued  = 0;
    pending = 1'b0;
    for (int c = 0; c < 20000 && issued < 1000; c++) begin
      if (!pending) begin
        rv.sub = 1'($urandom_range(0, 1));
        rv.cin = 1'($urandom_range(0, 1));
        rv.lhs = 8'($urandom_range(0, 255));
        rv.rhs = 8'($urandom_range(0, 255));
        pending = ($urandom_range(0, 99) < 70);
      end
      drive(rv, pending);
      bus.io_deq_ready = ($urandom_range(0, 99) < 70);
      #1;
      acc = bus.io_enq_valid && bus.io_enq_ready;
      tick();
      if (acc) begin
        issued++;
        pending = 1'b0;
      end
    end
    bus.io_enq_valid = 1'b0;
    bus.io_deq_ready = 1'b1;
    chk("rand_issued", 32'(issued), 32'd1000);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two ops in flight.
    bus.io_deq_ready = 1'b0;
    mr = '{1'b0, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    drive(mr, 1'b1);
    tick();
    mr.lhs = 8'hF0;
    mr.rhs = 8'h20;
    drive(mr, 1'b1);
    tick();
    bus.io_enq_valid = 1'b0;
    chk("mid_inflight_valid", 32'(bus.io_deq_valid), 32'd1);
    chk("mid_inflight_out",   32'(bus.io_deq_out),   32'h46);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.io_deq_valid), 32'd0);
    chk("mid_rst_out",   32'(bus.io_deq_out),   32'd0);
    chk("mid_rst_cout",  32'(bus.io_deq_cout),  32'd0);
    chk("mid_rst_ovf",   32'(bus.io_deq_ovf),   32'd0);
    chk("mid_rst_ready", 32'(bus.io_enq_ready), 32'd1);
    exp_q.delete();
    tick();
    #1 reset = 1'b1;
    bus.io_deq_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mid_no_stale%0d", c), 32'(bus.io_deq_valid), 32'd0);
    end
    run_vec(vecs[9], "post_rst");
    tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
